// File: rtl/ddmtd_phase_avg.sv
// Windowed phase averager for the DDMTD tag-difference stream: mean, min, max
// and peak-to-peak spread over 2^LOG2_NAVG samples, unwrapped about each window's first sample.
module ddmtd_phase_avg #(
  parameter int COUNTER_BIT_WIDTH = 16,
  parameter int LOG2_NAVG         = 4
) (
  input  logic                         clk_ddmtd_i,
  input  logic                         rst_n_ddmtdclk_i,
  input  logic                         enable_i,
  input  logic [COUNTER_BIT_WIDTH-1:0] phase_diff_i,
  input  logic                         phase_diff_p_i,
  output logic [COUNTER_BIT_WIDTH-1:0] avg_o,
  output logic [COUNTER_BIT_WIDTH-1:0] min_o,
  output logic [COUNTER_BIT_WIDTH-1:0] max_o,
  output logic [COUNTER_BIT_WIDTH-1:0] spread_o,
  output logic                         avg_p_o,
  output logic                         busy_o
);

  localparam int W  = COUNTER_BIT_WIDTH;
  localparam int SW = COUNTER_BIT_WIDTH + LOG2_NAVG;
  localparam int CW = LOG2_NAVG + 1;
  localparam logic [CW-1:0] NAVG = CW'(1 << LOG2_NAVG);

  typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          ref_q, ref_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic signed [W-1:0]   min_q, min_d;
  logic signed [W-1:0]   max_q, max_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          avg_q, avg_d;
  logic [W-1:0]          mino_q, mino_d;
  logic [W-1:0]          maxo_q, maxo_d;
  logic [W-1:0]          spread_q, spread_d;
  logic                  avg_p_q, avg_p_d;

  logic signed [W-1:0]   delta;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW-1:0]  sum_shift;
  logic signed [W-1:0]   min_next;
  logic signed [W-1:0]   max_next;
  logic [CW-1:0]         cnt_inc;

  // Each sample is unwrapped against the window reference, so a phase sitting
  // on the +/-2^(W-1) seam averages next to the seam rather than collapsing to 0.
  always_comb begin
    delta     = $signed(phase_diff_i - ref_q);
    sum_next  = sum_q + SW'(delta);
    sum_shift = sum_next >>> LOG2_NAVG;
    min_next  = (delta < min_q) ? delta : min_q;
    max_next  = (delta > max_q) ? delta : max_q;
    cnt_inc   = cnt_q + CW'(1);
  end

  // The pulse is registered together with the results on the edge that takes
  // the last sample, so avg_p_o and the new values appear in the DONE cycle.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    sum_d    = sum_q;
    min_d    = min_q;
    max_d    = max_q;
    cnt_d    = cnt_q;
    avg_d    = avg_q;
    mino_d   = mino_q;
    maxo_d   = maxo_q;
    spread_d = spread_q;
    avg_p_d  = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
      sum_d   = '0;
      min_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = FIRST;
        FIRST, DONE: begin
          if (state_q == DONE) state_d = FIRST;
          if (phase_diff_p_i) begin
            ref_d = phase_diff_i;
            sum_d = '0;
            min_d = '0;
            max_d = '0;
            cnt_d = CW'(1);
            if (LOG2_NAVG == 0) begin
              avg_d    = phase_diff_i;
              mino_d   = phase_diff_i;
              maxo_d   = phase_diff_i;
              spread_d = '0;
              avg_p_d  = 1'b1;
              state_d  = DONE;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (phase_diff_p_i) begin
            sum_d = sum_next;
            min_d = min_next;
            max_d = max_next;
            cnt_d = cnt_inc;
            if (cnt_inc == NAVG) begin
              avg_d    = ref_q + W'(sum_shift);
              mino_d   = ref_q + min_next;
              maxo_d   = ref_q + max_next;
              spread_d = max_next - min_next;
              avg_p_d  = 1'b1;
              state_d  = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ddmtd_i or negedge rst_n_ddmtdclk_i) begin
    if (!rst_n_ddmtdclk_i) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      sum_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      avg_q    <= '0;
      mino_q   <= '0;
      maxo_q   <= '0;
      spread_q <= '0;
      avg_p_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      avg_q    <= avg_d;
      mino_q   <= mino_d;
      maxo_q   <= maxo_d;
      spread_q <= spread_d;
      avg_p_q  <= avg_p_d;
    end
  end

  assign avg_o    = avg_q;
  assign min_o    = mino_q;
  assign max_o    = maxo_q;
  assign spread_o = spread_q;
  assign avg_p_o  = avg_p_q;
  assign busy_o   = (state_q == ACCUM);

endmodule

// File: tb/tb_ddmtd_phase_avg.sv
// Directed, table-driven bench for ddmtd_phase_avg (W=16, N=16) with
// hand-written sequences for back-to-back windows, enable abort and async reset.
module tb_ddmtd_phase_avg;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] phaseDiff;
  logic        phaseDiffP;
  logic [15:0] avgOut, minOut, maxOut, spreadOut;
  logic        avgPulse, busy;

  int checks = 0;
  int failures = 0;
  int pulseCount = 0;

  typedef struct {
    string name;
    int    a;
    int    b;
    bit    ramp;
    int    expAvg;
    int    expMin;
    int    expMax;
    int    expSpread;
  } vec_t;

  vec_t vecs[6];

  ddmtd_phase_avg #(.COUNTER_BIT_WIDTH(16), .LOG2_NAVG(4)) dut (
    .clk_ddmtd_i      (clock),
    .rst_n_ddmtdclk_i (rst_n),
    .enable_i         (enable),
    .phase_diff_i     (phaseDiff),
    .phase_diff_p_i   (phaseDiffP),
    .avg_o            (avgOut),
    .min_o            (minOut),
    .max_o            (maxOut),
    .spread_o         (spreadOut),
    .avg_p_o          (avgPulse),
    .busy_o           (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rst_n && avgPulse) pulseCount++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int val);
    @(negedge clock);
    phaseDiff  = val[15:0];
    phaseDiffP = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clock);
      phaseDiffP = 1'b0;
    end
  endtask

  task automatic checkResults(input string name, input int avg, input int mn, input int mx, input int spread);
    checkOutput({name, ".avg"},    int'($signed(avgOut)), avg);
    checkOutput({name, ".min"},    int'($signed(minOut)), mn);
    checkOutput({name, ".max"},    int'($signed(maxOut)), mx);
    checkOutput({name, ".spread"}, int'(spreadOut),       spread);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCount;
    int s;

    vecs[0] = '{"const100",  100,    100,    1'b0, 100,    100,   100,    0};
    vecs[1] = '{"wrapHi",    32767,  -32768, 1'b0, 32767,  32767, -32768, 1};
    vecs[2] = '{"floorNeg",  0,      -1,     1'b0, -1,     -1,    0,      1};
    vecs[3] = '{"ramp",      0,      0,      1'b1, 7,      0,     15,     15};
    vecs[4] = '{"symmetric", 1000,   -1000,  1'b0, 0,      -1000, 1000,   2000};
    vecs[5] = '{"straddle",  32760,  -32760, 1'b0, -32768, 32760, -32760, 16};

    rst_n      = 1'b0;
    enable     = 1'b0;
    phaseDiff  = '0;
    phaseDiffP = 1'b0;
    #23;
    checkResults("reset", 0, 0, 0, 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.pulse", int'(avgPulse), 0);
    @(negedge clock);
    rst_n  = 1'b1;
    enable = 1'b1;
    idleCycles(1);

    for (int v = 0; v < 6; v++) begin
      startCount = pulseCount;
      for (int i = 0; i < 16; i++) begin
        if (vecs[v].ramp) s = vecs[v].a + i;
        else              s = (i % 2 == 1) ? vecs[v].b : vecs[v].a;
        applyStimulus(s);
        if (i == 7) begin
          @(posedge clock); #1;
          checkOutput({vecs[v].name, ".busyMid"}, int'(busy), 1);
        end
      end
      @(posedge clock); #1;
      checkOutput({vecs[v].name, ".pulseLatency"}, int'(avgPulse), 1);
      idleCycles(3);
      checkOutput({vecs[v].name, ".pulseCount"}, pulseCount - startCount, 1);
      checkOutput({vecs[v].name, ".busyAfter"}, int'(busy), 0);
      checkResults(vecs[v].name, vecs[v].expAvg, vecs[v].expMin, vecs[v].expMax, vecs[v].expSpread);
    end

    // A strobe in the DONE cycle becomes the reference of the next window.
    startCount = pulseCount;
    for (int i = 0; i < 16; i++) applyStimulus(i);
    for (int i = 0; i < 16; i++) applyStimulus(5);
    idleCycles(3);
    checkOutput("doneStrobe.pulseCount", pulseCount - startCount, 2);
    checkResults("doneStrobe", 5, 5, 5, 0);

    startCount = pulseCount;
    for (int i = 0; i < 8; i++) applyStimulus(50);
    @(negedge clock);
    enable     = 1'b0;
    phaseDiffP = 1'b0;
    @(negedge clock);
    checkOutput("abort.busy", int'(busy), 0);
    checkOutput("abort.noPulse", pulseCount - startCount, 0);
    checkOutput("abort.avgHeld", int'($signed(avgOut)), 5);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(-200);
    idleCycles(3);
    checkOutput("abort.pulseCount", pulseCount - startCount, 1);
    checkResults("abort", -200, -200, -200, 0);

    for (int i = 0; i < 10; i++) applyStimulus(300);
    @(posedge clock); #1;
    checkOutput("midReset.busyBefore", int'(busy), 1);
    #2;
    rst_n      = 1'b0;
    phaseDiffP = 1'b0;
    #1;
    checkResults("midReset", 0, 0, 0, 0);
    checkOutput("midReset.busy", int'(busy), 0);
    @(negedge clock);
    rst_n = 1'b1;
    startCount = pulseCount;
    for (int i = 0; i < 16; i++) applyStimulus(-7);
    idleCycles(3);
    checkOutput("afterReset.pulseCount", pulseCount - startCount, 1);
    checkResults("afterReset", -7, -7, -7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
